// File: rtl/car_kinematics.sv
`default_nettype none
// ============================================================================
// Module   : car_kinematics
// Purpose  : Frame-rate motion model for the player car. Turns debounced
//            direction buttons into a heading, a speed and the sprite's
//            top-left screen position. State advances once per video frame.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   pclk       in   1  pixel clock (only clock)
//   rst        in   1  synchronous, active-low reset
//   frame_tick in   1  one-cycle pulse per frame
//   enable     in   1  motion enable; ticks are ignored while low
//   key        in   4  {R, L, D, U}, active-high, debounced
//   xpos       out 11  sprite top-left x
//   ypos       out 11  sprite top-left y
//   move_dir   out  2  heading: 0 U, 1 D, 2 L, 3 R
//   speed      out  4  current speed, pixels/frame
//   moving     out  1  high whenever the motion state is not STOP
// Build option
//   CAR_SCREEN_WRAP_EN : when defined, the sprite wraps around the screen
//                        edges instead of clamping at them and stopping.
// ============================================================================
module car_kinematics #(
  parameter int X_INIT  = 480,
  parameter int Y_INIT  = 352,
  parameter int X_MIN   = 0,
  parameter int X_MAX   = 960,
  parameter int Y_MIN   = 0,
  parameter int Y_MAX   = 704,
  parameter int V_MAX   = 8,
  parameter int ACC_DIV = 4
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        enable,
  input  logic [3:0]  key,
  output logic [10:0] xpos,
  output logic [10:0] ypos,
  output logic [1:0]  move_dir,
  output logic [3:0]  speed,
  output logic        moving
);

  localparam int ACC_W = (ACC_DIV > 1) ? $clog2(ACC_DIV) : 1;

  localparam logic [ACC_W-1:0]   ACC_LAST = ACC_W'(ACC_DIV - 1);
  localparam logic [3:0]         SPD_MAX  = 4'(V_MAX);
  localparam logic signed [11:0] XMIN_S   = 12'(X_MIN);
  localparam logic signed [11:0] XMAX_S   = 12'(X_MAX);
  localparam logic signed [11:0] YMIN_S   = 12'(Y_MIN);
  localparam logic signed [11:0] YMAX_S   = 12'(Y_MAX);
`ifdef CAR_SCREEN_WRAP_EN
  localparam logic signed [11:0] XSPAN_S  = 12'(X_MAX - X_MIN + 1);
  localparam logic signed [11:0] YSPAN_S  = 12'(Y_MAX - Y_MIN + 1);
`endif

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BRAKE = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [ACC_W-1:0]   acc_cnt, acc_cnt_n;
  logic               pend, pend_n;
  logic [3:0]         speed_n;
  logic [1:0]         dir_n;
  logic [10:0]        xpos_n, ypos_n;

  logic               tick_ok;
  logic               step;
  logic               req_v;
  logic [1:0]         req;
  logic [3:0]         spd_less2;
  logic signed [11:0] x_s, y_s, dlt;

  // A tick is only accepted while no position update is outstanding, so a
  // tick landing in the update cycle is simply dropped.
  assign tick_ok = frame_tick & enable & ~pend;
  assign step    = (acc_cnt == ACC_LAST);
  assign req_v   = |key;
  assign moving  = (state != ST_STOP);

  // Lowest set bit wins: U > D > L > R.
  always_comb begin
    req = 2'd0;
    if (key[0])      req = 2'd0;
    else if (key[1]) req = 2'd1;
    else if (key[2]) req = 2'd2;
    else if (key[3]) req = 2'd3;
  end

  assign spd_less2 = (speed > 4'd2) ? (speed - 4'd2) : 4'd0;

  always_comb begin
    state_n   = state;
    acc_cnt_n = acc_cnt;
    pend_n    = 1'b0;
    speed_n   = speed;
    dir_n     = move_dir;
    xpos_n    = xpos;
    ypos_n    = ypos;
    x_s       = signed'({1'b0, xpos});
    y_s       = signed'({1'b0, ypos});
    dlt       = signed'({8'd0, speed});

    if (tick_ok) begin
      // Speed/heading stage: results visible the cycle after the tick.
      pend_n    = 1'b1;
      acc_cnt_n = step ? '0 : acc_cnt + 1'b1;
      unique case (state)
        ST_STOP: begin
          if (req_v) begin
            dir_n   = req;
            speed_n = 4'd1;
            state_n = ST_RUN;
          end
        end
        ST_RUN: begin
          if (req_v && (req == move_dir)) begin
            if (step && (speed < SPD_MAX)) speed_n = speed + 4'd1;
          end else if (!req_v) begin
            if (step) begin
              speed_n = speed - 4'd1;
              if (speed == 4'd1) state_n = ST_STOP;
            end
          end else begin
            speed_n = spd_less2;
            state_n = (spd_less2 == 4'd0) ? ST_STOP : ST_BRAKE;
          end
        end
        ST_BRAKE: begin
          if (req_v && (req == move_dir)) begin
            state_n = ST_RUN;
          end else begin
            speed_n = spd_less2;
            if (spd_less2 == 4'd0) state_n = ST_STOP;
          end
        end
        default: begin
          state_n = ST_STOP;
          speed_n = 4'd0;
        end
      endcase
    end else if (pend) begin
      // Position stage: uses the speed/heading settled in the previous cycle.
      unique case (move_dir)
        2'd0:    y_s = y_s - dlt;
        2'd1:    y_s = y_s + dlt;
        2'd2:    x_s = x_s - dlt;
        default: x_s = x_s + dlt;
      endcase
`ifdef CAR_SCREEN_WRAP_EN
      if (x_s > XMAX_S)      x_s = x_s - XSPAN_S;
      else if (x_s < XMIN_S) x_s = x_s + XSPAN_S;
      if (y_s > YMAX_S)      y_s = y_s - YSPAN_S;
      else if (y_s < YMIN_S) y_s = y_s + YSPAN_S;
`else
      // Wall hit: pin to the bound and bring the car to rest.
      if ((x_s > XMAX_S) || (x_s < XMIN_S) ||
          (y_s > YMAX_S) || (y_s < YMIN_S)) begin
        speed_n = 4'd0;
        state_n = ST_STOP;
      end
      if (x_s > XMAX_S)      x_s = XMAX_S;
      else if (x_s < XMIN_S) x_s = XMIN_S;
      if (y_s > YMAX_S)      y_s = YMAX_S;
      else if (y_s < YMIN_S) y_s = YMIN_S;
`endif
      xpos_n = x_s[10:0];
      ypos_n = y_s[10:0];
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      state    <= ST_STOP;
      acc_cnt  <= '0;
      pend     <= 1'b0;
      speed    <= 4'd0;
      move_dir <= 2'd0;
      xpos     <= 11'(X_INIT);
      ypos     <= 11'(Y_INIT);
    end else begin
      state    <= state_n;
      acc_cnt  <= acc_cnt_n;
      pend     <= pend_n;
      speed    <= speed_n;
      move_dir <= dir_n;
      xpos     <= xpos_n;
      ypos     <= ypos_n;
    end
  end

endmodule
`default_nettype wire
